pwm_duty_sequencer: RTL and testbench

- Controller that owns the duty-cycle setting of a single PWM channel.
- Accepts debounced increment/decrement requests in manual mode, or runs an autonomous fade sequence (ramp up, hold, ramp down, hold) in auto mode.
- Applies duty changes glitch-free at PWM period boundaries and drives the PWM output.
- Sits between the top-level input switches and the PWM output pin.

---
 rtl/pwm_duty_sequencer_if.sv | 24 ++
 rtl/pwm_duty_sequencer.sv | 178 +++++++++++++++++
 tb/tb_pwm_duty_sequencer.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/pwm_duty_sequencer_if.sv
// Control/status bundle of the PWM duty sequencer: raw buttons and mode select
// in, PWM pin and applied-duty status out.
interface pwm_duty_sequencer_if #(
    parameter int DW = 4
);
    logic          inc_btn;
    logic          dec_btn;
    logic          auto_en;
    logic          pwm_out;
    logic [DW-1:0] duty;
    logic          at_max;
    logic          at_min;
    logic          busy;

    modport master (
        output inc_btn, dec_btn, auto_en,
        input  pwm_out, duty, at_max, at_min, busy
    );

    modport slave (
        input  inc_btn, dec_btn, auto_en,
        output pwm_out, duty, at_max, at_min, busy
    );
endinterface

// File: rtl/pwm_duty_sequencer.sv
// Single-channel PWM duty controller: debounced manual inc/dec or autonomous fade.
// Optional macro PWM_SHADOW_UPDATE_EN makes duty changes take effect only at period boundaries.
module pwm_duty_sequencer #(
    parameter int PERIOD       = 10,
    parameter int DW           = 4,
    parameter int INIT_DUTY    = 5,
    parameter int DEB_DIV      = 2,
    parameter int RAMP_PERIODS = 4,
    parameter int HOLD_PERIODS = 8
) (
    input logic                 clk,
    input logic                 rst_n,
    pwm_duty_sequencer_if.slave bus
);
    localparam int DEB_W  = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;
    localparam int STEP_W = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;
    localparam int HOLD_W = (HOLD_PERIODS > 1) ? $clog2(HOLD_PERIODS) : 1;

    localparam logic [DW-1:0]     DUTY_MAX  = DW'(PERIOD);
    localparam logic [DW-1:0]     CNT_LAST  = DW'(PERIOD - 1);
    localparam logic [DW-1:0]     DUTY_INIT = DW'(INIT_DUTY);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_DIV - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(RAMP_PERIODS - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_PERIODS - 1);

    typedef enum logic [2:0] {MANUAL, RAMP_UP, HOLD_HI, RAMP_DOWN, HOLD_LO} state_t;

    state_t            state, state_next;
    logic [DW-1:0]     pwm_cnt, duty_active, duty_shadow, shadow_next;
    logic [STEP_W-1:0] step_cnt, step_next;
    logic [HOLD_W-1:0] hold_cnt, hold_next;
    logic [DEB_W-1:0]  deb_cnt;
    logic              inc_s1, inc_s2, dec_s1, dec_s2;
    logic              period_end, tick, inc_pulse, dec_pulse;

    assign period_end = (pwm_cnt == CNT_LAST);
    assign tick       = (deb_cnt == DEB_LAST);

    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
            deb_cnt <= '0;
        end else begin
            pwm_cnt <= period_end ? '0 : pwm_cnt + 1'b1;
            deb_cnt <= tick ? '0 : deb_cnt + 1'b1;
        end
    end

    // Two-stage sampler per button; a press fires once, on the tick after first seen high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inc_s1 <= 1'b0;
            inc_s2 <= 1'b0;
            dec_s1 <= 1'b0;
            dec_s2 <= 1'b0;
        end else if (tick) begin
            inc_s1 <= bus.inc_btn;
            inc_s2 <= inc_s1;
            dec_s1 <= bus.dec_btn;
            dec_s2 <= dec_s1;
        end
    end

    assign inc_pulse = inc_s1 & ~inc_s2 & tick;
    assign dec_pulse = dec_s1 & ~dec_s2 & tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= MANUAL;
            duty_shadow <= DUTY_INIT;
            step_cnt    <= '0;
            hold_cnt    <= '0;
        end else begin
            state       <= state_next;
            duty_shadow <= shadow_next;
            step_cnt    <= step_next;
            hold_cnt    <= hold_next;
        end
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_next  = state;
        shadow_next = duty_shadow;
        step_next   = step_cnt;
        hold_next   = hold_cnt;
        case (state)
            MANUAL: begin
                if (bus.auto_en) begin
                    state_next = RAMP_UP;
                    step_next  = '0;
                end else if (inc_pulse && !dec_pulse && duty_shadow != DUTY_MAX) begin
                    shadow_next = duty_shadow + 1'b1;
                end else if (dec_pulse && !inc_pulse && duty_shadow != '0) begin
                    shadow_next = duty_shadow - 1'b1;
                end
            end
            RAMP_UP: begin
                if (period_end) begin
                    if (duty_shadow == DUTY_MAX) begin
                        state_next = HOLD_HI;
                        step_next  = '0;
                        hold_next  = '0;
                    end else if (step_cnt == STEP_LAST) begin
                        shadow_next = duty_shadow + 1'b1;
                        step_next   = '0;
                    end else begin
                        step_next = step_cnt + 1'b1;
                    end
                end
            end
            HOLD_HI: begin
                if (period_end) begin
                    if (hold_cnt == HOLD_LAST) begin
                        state_next = RAMP_DOWN;
                        hold_next  = '0;
                        step_next  = '0;
                    end else begin
                        hold_next = hold_cnt + 1'b1;
                    end
                end
            end
            RAMP_DOWN: begin
                if (period_end) begin
                    if (duty_shadow == '0) begin
                        state_next = HOLD_LO;
                        step_next  = '0;
                        hold_next  = '0;
                    end else if (step_cnt == STEP_LAST) begin
                        shadow_next = duty_shadow - 1'b1;
                        step_next   = '0;
                    end else begin
                        step_next = step_cnt + 1'b1;
                    end
                end
            end
            HOLD_LO: begin
                if (period_end) begin
                    if (hold_cnt == HOLD_LAST) begin
                        state_next = RAMP_UP;
                        hold_next  = '0;
                        step_next  = '0;
                    end else begin
                        hold_next = hold_cnt + 1'b1;
                    end
                end
            end
            default: state_next = MANUAL;
        endcase

        // Leaving auto mode freezes the duty where the fade left it.
        if (state != MANUAL && !bus.auto_en) begin
            state_next  = MANUAL;
            shadow_next = duty_shadow;
            step_next   = '0;
            hold_next   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_active <= DUTY_INIT;
        end else begin
`ifdef PWM_SHADOW_UPDATE_EN
            if (period_end) duty_active <= duty_shadow;
`else
            duty_active <= duty_shadow;
`endif
        end
    end

    assign bus.pwm_out = (pwm_cnt < duty_active);
    assign bus.duty    = duty_active;
    assign bus.at_max  = (duty_active == DUTY_MAX);
    assign bus.at_min  = (duty_active == '0);
    assign bus.busy    = (state != MANUAL);
endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Directed bench for pwm_duty_sequencer: manual inc/dec, saturation, auto fade
// timeline, auto exit mid-ramp and asynchronous reset mid-hold.
module tb_pwm_duty_sequencer;
    localparam int PERIOD = 10;
    localparam int DW     = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_pass  = 0;
    int   n_total = 0;
    int   cyc     = 0;

    pwm_duty_sequencer_if #(.DW(DW)) bus ();

    pwm_duty_sequencer #(
        .PERIOD(PERIOD), .DW(DW), .INIT_DUTY(5), .DEB_DIV(2),
        .RAMP_PERIODS(4), .HOLD_PERIODS(8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int actual, input int expected);
        n_total++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
    endtask

    task automatic high_count(output int n);
        n = 0;
        repeat (PERIOD) begin
            @(negedge clk);
            n += int'(bus.pwm_out);
        end
    endtask

    task automatic press(input bit inc, input bit dec, input int hold_clks);
        bus.inc_btn = inc;
        bus.dec_btn = dec;
        repeat (hold_clks) @(negedge clk);
        bus.inc_btn = 1'b0;
        bus.dec_btn = 1'b0;
        repeat (2 * PERIOD) @(negedge clk);
    endtask

    // Lands on the negedge where the PWM counter has just wrapped to 0 (duty must be 1..PERIOD-1).
    task automatic sync_period_start();
        logic prev;
        bit   found;
        found = 1'b0;
        prev  = bus.pwm_out;
        for (int i = 0; i < 3 * PERIOD && !found; i++) begin
            @(negedge clk);
            if (!prev && bus.pwm_out) found = 1'b1;
            prev = bus.pwm_out;
        end
        check("sync_period_start", int'(found), 1);
        cyc = 0;
    endtask

    task automatic adv_to(input int k);
        repeat (k - cyc) @(negedge clk);
        cyc = k;
    endtask

    initial begin
        int n;
        bus.inc_btn = 1'b0;
        bus.dec_btn = 1'b0;
        bus.auto_en = 1'b0;
        rst_n       = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_duty", int'(bus.duty), 5);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_at_max", int'(bus.at_max), 0);
        check("rst_at_min", int'(bus.at_min), 0);
        check("rst_pwm_out", int'(bus.pwm_out), 1);
        rst_n = 1'b1;
        high_count(n);
        check("rst_high_count", n, 5);

        press(1'b1, 1'b0, 4);
        check("inc_duty", int'(bus.duty), 6);
        high_count(n);
        check("inc_high_count", n, 6);
        press(1'b1, 1'b0, 20);
        check("long_press_single", int'(bus.duty), 7);

        repeat (6) press(1'b1, 1'b0, 4);
        check("sat_max_duty", int'(bus.duty), 10);
        check("sat_max_flag", int'(bus.at_max), 1);
        check("sat_max_min_flag", int'(bus.at_min), 0);
        high_count(n);
        check("sat_max_high_count", n, 10);

        repeat (11) press(1'b0, 1'b1, 4);
        check("sat_min_duty", int'(bus.duty), 0);
        check("sat_min_flag", int'(bus.at_min), 1);
        check("sat_min_max_flag", int'(bus.at_max), 0);
        high_count(n);
        check("sat_min_high_count", n, 0);

        repeat (5) press(1'b1, 1'b0, 4);
        check("back_to_5", int'(bus.duty), 5);
        press(1'b1, 1'b1, 4);
        check("both_pressed", int'(bus.duty), 5);

        // Auto run 1: full fade cycle, then reset during the second HOLD_HI.
        sync_period_start();
        bus.auto_en = 1'b1;
        adv_to(20);
        check("auto_start_duty", int'(bus.duty), 5);
        check("auto_busy", int'(bus.busy), 1);
        for (int i = 1; i <= 5; i++) begin
            adv_to(19 + 40 * i);
            check($sformatf("ramp_up_%0d", i), int'(bus.duty), 5 + i);
        end
        adv_to(230);
        bus.dec_btn = 1'b1;
        adv_to(240);
        bus.dec_btn = 1'b0;
        adv_to(285);
        check("hold_hi_duty", int'(bus.duty), 10);
        check("hold_hi_at_max", int'(bus.at_max), 1);
        check("hold_hi_busy", int'(bus.busy), 1);
        for (int i = 1; i <= 10; i++) begin
            adv_to(309 + 40 * i);
            check($sformatf("ramp_down_%0d", i), int'(bus.duty), 10 - i);
        end
        check("ramp_down_at_min", int'(bus.at_min), 1);
        adv_to(775);
        check("hold_lo_duty", int'(bus.duty), 0);
        check("hold_lo_busy", int'(bus.busy), 1);
        adv_to(839);
        check("reramp_duty", int'(bus.duty), 1);
        adv_to(1225);
        check("hold_hi2_duty", int'(bus.duty), 10);
        check("hold_hi2_busy", int'(bus.busy), 1);

        rst_n = 1'b0;
        #1;
        check("async_rst_duty", int'(bus.duty), 5);
        check("async_rst_busy", int'(bus.busy), 0);
        check("async_rst_pwm_out", int'(bus.pwm_out), 1);
        check("async_rst_at_max", int'(bus.at_max), 0);
        bus.auto_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Auto run 2: drop auto_en mid-RAMP_DOWN at duty 3.
        sync_period_start();
        bus.auto_en = 1'b1;
        adv_to(589);
        check("run2_duty_3", int'(bus.duty), 3);
        check("run2_busy", int'(bus.busy), 1);
        bus.auto_en = 1'b0;
        adv_to(590);
        check("exit_busy", int'(bus.busy), 0);
        check("exit_duty", int'(bus.duty), 3);
        press(1'b1, 1'b0, 4);
        check("exit_inc_duty", int'(bus.duty), 4);
        high_count(n);
        check("exit_inc_high_count", n, 4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
